// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// Each command takes three cycles: IDLE (arbitrate and latch),
// ACCESS (one memory strobe), RESP (capture read data), then ack on
// return to IDLE.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   req/we/addr/wdata{0,1}  requester commands, held until ack
//   ack{0,1}, rdata{0,1}    one-cycle completion pulse and read result
//   mem_read, mem_write     memory strobes, high only in ACCESS
//   mem_addr, mem_data_in   memory address / write data, held between commands
//   mem_data_out            memory read data, valid in the cycle after mem_read
//   busy                    high whenever the FSM is not in IDLE
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nx;

  logic elig0, elig1;
  logic grant_vld, grant_idx;
  logic last_grant;   // index of the requester granted most recently
  logic lat_idx;      // requester owning the command in flight
  logic lat_we;       // command in flight is a write

  // A requester being acked this cycle still holds its old command on
  // req, so it is masked for one cycle to avoid re-issuing it.
  always_comb begin
    state_nx  = state;
    elig0     = req0 & ~ack0;
    elig1     = req1 & ~ack1;
    grant_vld = elig0 | elig1;
    grant_idx = (elig0 & elig1) ? ~last_grant : elig1;
    case (state)
      IDLE:    if (grant_vld) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      busy        <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
      last_grant  <= 1'b1;  // requester 0 wins the first tie
      lat_idx     <= 1'b0;
      lat_we      <= 1'b0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      busy      <= (state_nx != IDLE);
      case (state)
        IDLE: if (grant_vld) begin
          last_grant <= grant_idx;
          lat_idx    <= grant_idx;
          lat_we     <= grant_idx ? we1 : we0;
          // mem_addr / mem_data_in double as the command latch, so they
          // are already stable when the strobe rises in ACCESS.
          mem_addr   <= grant_idx ? addr1 : addr0;
          if (grant_idx ? we1 : we0)
            mem_data_in <= grant_idx ? wdata1 : wdata0;
          mem_write  <= grant_idx ? we1 : we0;
          mem_read   <= grant_idx ? ~we1 : ~we0;
        end
        RESP: begin
          if (lat_idx) ack1 <= 1'b1;
          else         ack0 <= 1'b1;
          if (!lat_we) begin
            if (lat_idx) rdata1 <= mem_data_out;
            else         rdata0 <= mem_data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural memory, queue-fed requesters, a
// cycle-count based transaction model checked every cycle, and directed
// scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, mem_read, mem_write, busy;
  logic [DW-1:0] rdata0, rdata1, mem_data_in;
  logic [DW-1:0] mem_data_out = '0;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
  typedef struct { int cyc; int idx; logic [DW-1:0] rd; } ack_ev_t;
  typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] d; } stb_ev_t;

  cmd_t    q0[$], q1[$];
  ack_ev_t acks[$];
  stb_ev_t stbs[$];
  int      n_chk = 0, n_fail = 0;
  int      cyc = 0;
  logic [DW-1:0] mem_env [32];
  logic [DW-1:0] mem_m   [32];

  function automatic logic [DW-1:0] pre(int a);
    return DW'(a * 7 + 17);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: write commits and read data update on the edge ending ACCESS.
  always @(posedge clk) begin
    if (mem_write) mem_env[mem_addr] <= mem_data_in;
    if (mem_read)  mem_data_out <= mem_env[mem_addr];
  end

  // Requesters: present queue heads, retire a head once its ack is seen.
  logic s0, s1;
  initial begin
    forever begin
      @(negedge clk);
      s0 = ack0;
      s1 = ack1;
      @(posedge clk);
      #1;
      if (s0 && q0.size() > 0) q0.delete(0);
      if (s1 && q1.size() > 0) q1.delete(0);
      req0 = (q0.size() > 0);
      req1 = (q1.size() > 0);
      if (req0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data; end
      if (req1) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data; end
    end
  end

  // Transaction model: a grant sampled at the end of cycle g gives the
  // strobe in g+1, data capture in g+2 and the ack in g+3.
  int            g_cyc = -100, g_idx = 0;
  logic          g_we = 1'b0;
  logic [AW-1:0] g_addr = '0;
  logic [DW-1:0] g_wd = '0;
  bit            m_last = 1'b1;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_din = '0, e_rd0 = '0, e_rd1 = '0;

  always @(negedge clk) begin : model
    int n;
    bit acc, rsp, ackc, idle, el0, el1, w;
    n    = cyc;
    acc  = (n == g_cyc + 1);
    rsp  = (n == g_cyc + 2);
    ackc = (n == g_cyc + 3);
    chk("mem_write",   mem_write,   acc && g_we);
    chk("mem_read",    mem_read,    acc && !g_we);
    chk("mem_addr",    mem_addr,    e_addr);
    chk("mem_data_in", mem_data_in, e_din);
    chk("busy",        busy,        acc || rsp);
    chk("ack0",        ack0,        ackc && g_idx == 0);
    chk("ack1",        ack1,        ackc && g_idx == 1);
    chk("rdata0",      rdata0,      e_rd0);
    chk("rdata1",      rdata1,      e_rd1);
    chk("ack_excl",    ack0 && ack1, 0);
    if (mem_read || mem_write)
      stbs.push_back('{cyc: n, we: mem_write, addr: mem_addr, d: mem_data_in});
    if (ack0) acks.push_back('{cyc: n, idx: 0, rd: rdata0});
    if (ack1) acks.push_back('{cyc: n, idx: 1, rd: rdata1});

    if (acc && g_we) mem_m[g_addr] = g_wd;
    if (reset) begin
      g_cyc = -100; m_last = 1'b1;
      e_addr = '0; e_din = '0; e_rd0 = '0; e_rd1 = '0;
    end else begin
      if (rsp && !g_we) begin
        if (g_idx == 1) e_rd1 = mem_m[g_addr];
        else            e_rd0 = mem_m[g_addr];
      end
      idle = (g_cyc < 0) || (n >= g_cyc + 3);
      el0  = req0 && !(ackc && g_idx == 0);
      el1  = req1 && !(ackc && g_idx == 1);
      if (idle && (el0 || el1)) begin
        w      = (el0 && el1) ? !m_last : el1;
        m_last = w;
        g_cyc  = n;
        g_idx  = w ? 1 : 0;
        g_we   = w ? we1 : we0;
        g_addr = w ? addr1 : addr0;
        g_wd   = w ? wdata1 : wdata0;
        e_addr = g_addr;
        if (g_we) e_din = g_wd;
      end
    end
  end

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !req0 && !req1 && !busy) done = 1'b1;
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: requests still pending after 300 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
  endtask

  initial begin : main
    int r, nacks;
    bit hit;
    for (int i = 0; i < 32; i++) begin mem_env[i] = pre(i); mem_m[i] = pre(i); end

    // Reset state
    @(posedge clk); #2;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_memaddr", mem_addr, 0);
    chk("rst_rdata1", rdata1, 0);

    // Write addr 5 = A5 from requester 0
    acks.delete(); stbs.delete();
    r = cyc + 1;
    q0.push_back('{we: 1'b1, addr: 5'd5, data: 8'hA5});
    wait_drain();
    chk("t1_nstb", stbs.size(), 1);
    chk("t1_nack", acks.size(), 1);
    if (stbs.size() > 0 && acks.size() > 0) begin
      chk("t1_stb_cyc", stbs[0].cyc, r + 1);
      chk("t1_stb_we", stbs[0].we, 1);
      chk("t1_stb_addr", stbs[0].addr, 5);
      chk("t1_stb_data", stbs[0].d, 8'hA5);
      chk("t1_ack_cyc", acks[0].cyc, r + 3);
      chk("t1_ack_idx", acks[0].idx, 0);
    end

    // Read addr 5 from requester 1
    acks.delete(); stbs.delete();
    q1.push_back('{we: 1'b0, addr: 5'd5, data: 8'h00});
    wait_drain();
    if (stbs.size() > 0 && acks.size() > 0) begin
      chk("t2_stb_we", stbs[0].we, 0);
      chk("t2_stb_addr", stbs[0].addr, 5);
      chk("t2_ack_idx", acks[0].idx, 1);
      chk("t2_rdata1", acks[0].rd, 8'hA5);
    end else chk("t2_events", stbs.size() + acks.size(), 2);

    // Both held from reset: 0,1,0,1, three cycles apart
    pulse_reset();
    @(negedge clk);
    acks.delete(); stbs.delete();
    for (int i = 0; i < 2; i++) begin
      q0.push_back('{we: 1'b1, addr: AW'(1 + i), data: DW'(8'h30 + i)});
      q1.push_back('{we: 1'b1, addr: AW'(3 + i), data: DW'(8'h40 + i)});
    end
    wait_drain();
    chk("t3_nack", acks.size(), 4);
    if (acks.size() == 4) begin
      chk("t3_idx0", acks[0].idx, 0);
      chk("t3_idx1", acks[1].idx, 1);
      chk("t3_idx2", acks[2].idx, 0);
      chk("t3_idx3", acks[3].idx, 1);
      for (int i = 1; i < 4; i++) chk("t3_spacing", acks[i].cyc - acks[i-1].cyc, 3);
    end

    // req0 streaming, req1 raised once: served right after current req0 command
    acks.delete(); stbs.delete();
    for (int i = 0; i < 4; i++)
      q0.push_back('{we: 1'b1, addr: AW'(8 + i), data: DW'(8'h50 + i)});
    @(negedge clk);
    q1.push_back('{we: 1'b1, addr: 5'd12, data: 8'h66});
    wait_drain();
    chk("t4_nack", acks.size(), 5);
    if (acks.size() == 5) begin
      chk("t4_idx0", acks[0].idx, 0);
      chk("t4_idx1", acks[1].idx, 1);
      chk("t4_idx2", acks[2].idx, 0);
    end

    // Reads at both address extremes
    acks.delete(); stbs.delete();
    q0.push_back('{we: 1'b0, addr: 5'd0,  data: 8'h00});
    q1.push_back('{we: 1'b0, addr: 5'd31, data: 8'h00});
    wait_drain();
    chk("t6_nack", acks.size(), 2);
    foreach (acks[i]) begin
      if (acks[i].idx == 0) chk("t6_rdata_a0", acks[i].rd, 8'h11);
      else                  chk("t6_rdata_a31", acks[i].rd, 8'hEA);
    end

    // Reset during ACCESS of a write to addr 31
    acks.delete(); stbs.delete();
    q0.push_back('{we: 1'b1, addr: 5'd31, data: 8'h77});
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(posedge clk); #2;
      if (mem_write) hit = 1'b1;
    end
    chk("t5_access_seen", hit, 1);
    reset = 1'b1; req0 = 1'b0; q0.delete();
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_mem_write", mem_write, 0);
    chk("t5_mem_read", mem_read, 0);
    nacks = acks.size();
    repeat (6) @(negedge clk);
    chk("t5_no_ack", acks.size(), nacks);
    chk("t5_no_ack0", nacks, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
